// File: rtl/ps2_pkg.sv
// ps2_pkg
//   Shared definitions for the PS/2 host transmitter: the FSM state type,
//   PS/2 frame constants and the parity helper.
//   No ports.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    BITS,
    ACK,
    RECOVER
  } ps2_state_e;

  // Host-to-device frame: 8 data bits, parity, stop, then the device ack edge.
  localparam int unsigned PS2_FRAME_EDGES = 11;
  localparam int unsigned PS2_DATA_BITS   = 8;
  localparam bit          PS2_PARITY_ODD  = 1'b1;

  function automatic logic ps2_parity(input logic [7:0] b);
    return PS2_PARITY_ODD ? ~^b : ^b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if
//   Bundles the host byte handshake and the PS/2 pad signals of ps2_host_tx.
//   in_en / data            : host byte request and command byte
//   ready / done / err      : idle flag, success pulse, failure pulse
//   ps2_clk / ps2_data      : line levels as read from the pads
//   ps2_clk_oe / ps2_data_oe: 1 = pull the line low, 0 = release
//   Modports: slave = transmitter side, master = host/pad side.
interface ps2_host_tx_if;

  logic       in_en;
  logic [7:0] data;
  logic       ps2_clk;
  logic       ps2_data;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       ready;
  logic       done;
  logic       err;

  modport slave (
    input  in_en, data, ps2_clk, ps2_data,
    output ps2_clk_oe, ps2_data_oe, ready, done, err
  );

  modport master (
    output in_en, data, ps2_clk, ps2_data,
    input  ps2_clk_oe, ps2_data_oe, ready, done, err
  );

endinterface

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge
//   Two-flop synchroniser for an asynchronous line plus a falling-edge
//   detector on the synchronised value. All flops reset to 1 (idle line).
//   sys_clk : system clock
//   rst_n   : asynchronous active-low reset
//   i_line  : raw line from the pad
//   o_sync  : synchronised line level
//   o_fall  : one-cycle flag on a synchronised 1->0 transition
module ps2_sync_edge (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic i_line,
  output logic o_sync,
  output logic o_fall
);

  // [0] metastability flop, [1] synchronised level, [2] previous level
  logic [2:0] r_sh;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh <= 3'b111;
    end else begin
      r_sh <= {r_sh[1:0], i_line};
    end
  end

  assign o_sync = r_sh[1];
  assign o_fall = r_sh[2] & ~r_sh[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
//   PS/2 host-to-device byte transmitter. Inhibits the clock, issues the
//   request-to-send start bit, shifts data/parity/stop on device clock
//   falling edges, checks the device ack and waits for the bus to go idle.
//   sys_clk : system clock (single domain)
//   rst_n   : asynchronous active-low reset
//   bus     : ps2_host_tx_if.slave (byte handshake, pad levels, pad enables)
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | ready, lines released, waiting for in_en
//   INHIBIT | clock held low for INHIBIT_CYC cycles
//   START   | clock and data low for one cycle (start bit)
//   BITS    | clock released, next bit driven on each device falling edge
//   ACK     | stop bit out, waiting for the ack edge
//   RECOVER | waiting for both lines high before reporting
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned INHIBIT_US = 100,
  parameter int unsigned TIMEOUT_US = 15000
) (
  input  logic           sys_clk,
  input  logic           rst_n,
  ps2_host_tx_if.slave   bus
);

  localparam int unsigned INHIBIT_CYC = CLK_HZ / 1_000_000 * INHIBIT_US;
  localparam int unsigned TIMEOUT_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int unsigned MAX_CYC     = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int unsigned CNT_W       = $clog2(MAX_CYC) + 1;

  // Edge index (0-based) on which the stop bit goes out.
  localparam logic [3:0] STOP_IDX = 4'(PS2_FRAME_EDGES - 2);

  ps2_state_e       r_state;
  ps2_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       r_bit_idx;
  logic [3:0]       w_bit_idx_nxt;
  logic [7:0]       r_byte;
  logic [7:0]       w_byte_nxt;
  logic             r_parity;
  logic             w_parity_nxt;
  logic             r_drive;
  logic             w_drive_nxt;
  logic             r_acked;
  logic             w_acked_nxt;
  logic [1:0]       r_data_sync;

  logic w_clk_s;
  logic w_clk_fall;
  logic w_data_s;
  logic w_timeout;
  logic w_inhibit_end;
  logic w_clk_oe;
  logic w_data_oe;
  logic w_ready;
  logic w_done;
  logic w_err;

  ps2_sync_edge u_clk_sync (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .i_line  (bus.ps2_clk),
    .o_sync  (w_clk_s),
    .o_fall  (w_clk_fall)
  );

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_sync <= 2'b11;
    end else begin
      r_data_sync <= {r_data_sync[0], bus.ps2_data};
    end
  end

  assign w_data_s = r_data_sync[1];

  assign w_inhibit_end = (r_cnt == CNT_W'(INHIBIT_CYC - 1));
  assign w_timeout     = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt + CNT_W'(1);
    w_bit_idx_nxt = r_bit_idx;
    w_byte_nxt    = r_byte;
    w_parity_nxt  = r_parity;
    w_drive_nxt   = r_drive;
    w_acked_nxt   = r_acked;
    w_clk_oe      = 1'b0;
    w_data_oe     = 1'b0;
    w_ready       = 1'b0;
    w_done        = 1'b0;
    w_err         = 1'b0;

    case (r_state)
      IDLE: begin
        w_ready   = 1'b1;
        w_cnt_nxt = '0;
        if (bus.in_en) begin
          w_byte_nxt   = bus.data;
          w_parity_nxt = ps2_parity(bus.data);
          w_state_nxt  = INHIBIT;
        end
      end

      INHIBIT: begin
        w_clk_oe = 1'b1;
        if (w_inhibit_end) begin
          w_state_nxt = START;
        end
      end

      START: begin
        w_clk_oe      = 1'b1;
        w_data_oe     = 1'b1;
        w_cnt_nxt     = '0;
        w_bit_idx_nxt = '0;
        w_drive_nxt   = 1'b1;    // start bit stays on the line into BITS
        w_acked_nxt   = 1'b0;
        w_state_nxt   = BITS;
      end

      BITS: begin
        w_data_oe = r_drive;
        // An edge takes priority over a coincident timeout: the device is alive.
        if (w_clk_fall) begin
          w_cnt_nxt     = '0;
          w_bit_idx_nxt = r_bit_idx + 4'd1;
          if (r_bit_idx < 4'(PS2_DATA_BITS)) begin
            w_drive_nxt = ~r_byte[r_bit_idx[2:0]];
          end else if (r_bit_idx != STOP_IDX) begin
            w_drive_nxt = ~r_parity;
          end else begin
            w_drive_nxt = 1'b0;
            w_state_nxt = ACK;
          end
        end else if (w_timeout) begin
          w_data_oe   = 1'b0;
          w_err       = 1'b1;
          w_state_nxt = IDLE;
        end
      end

      ACK: begin
        if (w_clk_fall) begin
          w_cnt_nxt   = '0;
          w_state_nxt = RECOVER;
          if (!w_data_s) begin
            w_acked_nxt = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end else if (w_timeout) begin
          w_err       = 1'b1;
          w_state_nxt = IDLE;
        end
      end

      RECOVER: begin
        // A nacked frame already reported err at the ack edge, so it exits quietly.
        if (w_clk_s && w_data_s) begin
          w_done      = r_acked;
          w_state_nxt = IDLE;
        end else if (w_timeout) begin
          w_err       = 1'b1;
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_byte    <= '0;
      r_parity  <= 1'b0;
      r_drive   <= 1'b0;
      r_acked   <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_byte    <= w_byte_nxt;
      r_parity  <= w_parity_nxt;
      r_drive   <= w_drive_nxt;
      r_acked   <= w_acked_nxt;
    end
  end

  assign bus.ps2_clk_oe  = w_clk_oe;
  assign bus.ps2_data_oe = w_data_oe;
  assign bus.ready       = w_ready;
  assign bus.done        = w_done;
  assign bus.err         = w_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

  localparam int INHIBIT_CYC = 100;
  localparam int TIMEOUT_CYC = 2000;
  // Pad change to internal fall flag: two synchroniser flops.
  localparam int SYNC_LAT    = 2;

  localparam int M_ACK     = 0;
  localparam int M_NACK    = 1;
  localparam int M_STALL   = 2;
  localparam int M_RESET   = 3;

  typedef struct {
    logic [7:0] data;
    int         mode;
    bit         poke;
    logic       exp_par;
    int         exp_done;
    int         exp_err;
  } vec_t;

  logic sys_clk;
  logic rst_n;
  logic dev_clk_low;
  logic dev_data_low;

  int n_chk  = 0;
  int n_fail = 0;
  int n_done = 0;
  int n_err  = 0;
  int n_both = 0;

  vec_t vecs [5];

  ps2_host_tx_if bus ();

  ps2_host_tx #(
    .CLK_HZ     (1_000_000),
    .INHIBIT_US (100),
    .TIMEOUT_US (2000)
  ) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  // Open-drain pads: either side may pull low.
  assign bus.ps2_clk  = ~(bus.ps2_clk_oe  | dev_clk_low);
  assign bus.ps2_data = ~(bus.ps2_data_oe | dev_data_low);

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  always @(negedge sys_clk) begin
    if (bus.done) n_done <= n_done + 1;
    if (bus.err)  n_err  <= n_err + 1;
    if (bus.done && bus.err) n_both <= n_both + 1;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not reach summary, fails=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input string tag, input logic [7:0] d, input int mode, input bit poke,
                      input logic exp_par, input int exp_done, input int exp_err);
    int n;
    int t;
    int done0;
    int err0;
    logic [10:0] seen;
    logic [10:0] exp_frame;
    done0 = n_done;
    err0  = n_err;
    seen  = '0;

    @(negedge sys_clk);
    bus.in_en = 1'b1;
    bus.data  = d;
    @(negedge sys_clk);
    bus.in_en = 1'b0;
    bus.data  = 8'h00;

    n = 0;
    while (bus.ps2_clk_oe && !bus.ps2_data_oe && n < 1000) begin
      n++;
      if (poke && n == 10) begin
        chk({tag, "_ready_busy"}, int'(bus.ready), 0);
        bus.in_en = 1'b1;
        bus.data  = 8'h55;
      end else begin
        bus.in_en = 1'b0;
      end
      @(negedge sys_clk);
    end
    bus.in_en = 1'b0;
    chk({tag, "_inhibit_len"}, n, INHIBIT_CYC);

    n = 0;
    while (bus.ps2_clk_oe && bus.ps2_data_oe && n < 10) begin
      n++;
      @(negedge sys_clk);
    end
    chk({tag, "_start_len"}, n, 1);
    chk({tag, "_bits_entry_oe"}, int'({bus.ps2_clk_oe, bus.ps2_data_oe}), 1);

    // Device model: 100-cycle clock period; samples data late in the high phase.
    for (int k = 1; k <= 11; k++) begin
      repeat (40) @(negedge sys_clk);
      seen[k-1] = bus.ps2_data;
      if (k == 11 && mode == M_ACK) dev_data_low = 1'b1;
      repeat (10) @(negedge sys_clk);
      dev_clk_low = 1'b1;

      if (mode == M_STALL && k == 4) begin
        t = 0;
        while (!bus.err && t < 3000) begin
          @(negedge sys_clk);
          t++;
          if (t == 50) dev_clk_low = 1'b0;
        end
        dev_clk_low = 1'b0;
        chk({tag, "_timeout_cycles"}, t, TIMEOUT_CYC + SYNC_LAT);
        chk({tag, "_timeout_oe"}, int'({bus.ps2_clk_oe, bus.ps2_data_oe}), 0);
        @(negedge sys_clk);
        chk({tag, "_timeout_ready"}, int'(bus.ready), 1);
        break;
      end

      if (mode == M_RESET && k == 6) begin
        repeat (5) @(negedge sys_clk);
        rst_n = 1'b0;
        #1;
        chk({tag, "_rst_oe"}, int'({bus.ps2_clk_oe, bus.ps2_data_oe}), 0);
        chk({tag, "_rst_ready"}, int'(bus.ready), 1);
        dev_clk_low = 1'b0;
        repeat (4) @(negedge sys_clk);
        rst_n = 1'b1;
        @(negedge sys_clk);
        chk({tag, "_rst_idle_ready"}, int'(bus.ready), 1);
        break;
      end

      repeat (50) @(negedge sys_clk);
      dev_clk_low  = 1'b0;
      dev_data_low = 1'b0;
    end

    if (mode == M_ACK || mode == M_NACK) begin
      t = 0;
      while (!bus.ready && t < 200) begin
        @(negedge sys_clk);
        t++;
      end
      chk({tag, "_ready_back"}, int'(bus.ready), 1);
      exp_frame = {1'b1, exp_par, d, 1'b0};
      chk({tag, "_frame"}, int'(seen), int'(exp_frame));
      chk({tag, "_released"}, int'({bus.ps2_clk_oe, bus.ps2_data_oe}), 0);
    end

    repeat (3) @(negedge sys_clk);
    chk({tag, "_done_cnt"}, n_done - done0, exp_done);
    chk({tag, "_err_cnt"}, n_err - err0, exp_err);
  endtask

  initial begin
    int err0;

    //            data   mode    poke  par   done err
    vecs[0] = '{8'hED, M_ACK,  1'b0, 1'b1, 1,   0};
    vecs[1] = '{8'h01, M_ACK,  1'b0, 1'b0, 1,   0};
    vecs[2] = '{8'hFF, M_ACK,  1'b0, 1'b1, 1,   0};
    vecs[3] = '{8'h3C, M_ACK,  1'b1, 1'b1, 1,   0};
    vecs[4] = '{8'h00, M_NACK, 1'b0, 1'b1, 0,   1};

    rst_n        = 1'b0;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    bus.in_en    = 1'b0;
    bus.data     = 8'h00;

    repeat (3) @(negedge sys_clk);
    chk("rst_ready", int'(bus.ready), 1);
    chk("rst_clk_oe", int'(bus.ps2_clk_oe), 0);
    chk("rst_data_oe", int'(bus.ps2_data_oe), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_err", int'(bus.err), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);

    // Device clock edges while idle must not start anything.
    err0 = n_err;
    repeat (3) begin
      dev_clk_low = 1'b1;
      repeat (20) @(negedge sys_clk);
      dev_clk_low = 1'b0;
      repeat (20) @(negedge sys_clk);
    end
    chk("idle_edges_ready", int'(bus.ready), 1);
    chk("idle_edges_oe", int'({bus.ps2_clk_oe, bus.ps2_data_oe}), 0);
    chk("idle_edges_err", n_err - err0, 0);

    for (int i = 0; i < 5; i++) begin
      send($sformatf("v%0d", i), vecs[i].data, vecs[i].mode, vecs[i].poke,
           vecs[i].exp_par, vecs[i].exp_done, vecs[i].exp_err);
    end

    send("stall", 8'hAA, M_STALL, 1'b0, 1'b1, 0, 1);
    send("midrst", 8'h12, M_RESET, 1'b0, 1'b1, 0, 0);
    send("after_rst", 8'hF4, M_ACK, 1'b0, 1'b0, 1, 0);

    chk("done_err_overlap", n_both, 0);

    $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameters SHALL be: CLK_HZ, default 100_000_000, sys_clk frequency; INHIBIT_US, default 100, clock-inhibit time; TIMEOUT_US, default 15000, maximum gap between device clock edges.
REQ-002 Ports SHALL be:
- sys_clk  in  1  system clock, single clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- in_en  in  1  host byte request strobe.
- data  in  8  command byte, sampled when in_en && ready.
- ps2_clk  in  1  PS/2 clock line as read from the pad.
- ps2_data  in  1  PS/2 data line as read from the pad.
- ps2_clk_oe  out  1  1 = pull clock line low; 0 = release.
- ps2_data_oe  out  1  1 = pull data line low; 0 = release.
- ready  out  1  idle, able to accept a byte.
- done  out  1  one-cycle pulse: byte sent and acknowledged.
- err  out  1  one-cycle pulse: timeout or missing ack.

Function
REQ-003 ps2_clk and ps2_data SHALL pass through a 2-flop synchroniser; a falling edge SHALL be a synchronised 1->0 transition on ps2_clk, flagged for one sys_clk cycle.
REQ-004 FSM states SHALL be IDLE, INHIBIT, START, BITS, ACK, RECOVER.
REQ-005 IDLE: ready=1, both oe=0; in_en=1 SHALL latch data, compute odd parity (~^data), clear the cycle counter, and enter INHIBIT next cycle; in_en in any other state SHALL be ignored.
REQ-006 INHIBIT: ps2_clk_oe=1, ps2_data_oe=0, for exactly INHIBIT_CYC = CLK_HZ/1_000_000*INHIBIT_US cycles, then enter START.
REQ-007 START: ps2_clk_oe=1 and ps2_data_oe=1 for one cycle (start bit 0), then enter BITS with ps2_clk_oe=0 and ps2_data_oe held at 1.
REQ-008 BITS: on each falling edge the next bit SHALL be driven (ps2_data_oe = ~bit): edges 1-8 data[0]..data[7] LSB first, edge 9 parity, edge 10 stop (ps2_data_oe=0); after edge 10, enter ACK.
REQ-009 ACK: on the next falling edge (edge 11), synchronised ps2_data=0 SHALL mean acknowledged and enter RECOVER; ps2_data=1 SHALL pulse err and enter RECOVER.
REQ-010 RECOVER: wait until both synchronised lines are 1, then pulse done (only if acknowledged) and return to IDLE.
REQ-011 A timeout counter SHALL clear on entering BITS and on every falling edge; reaching TIMEOUT_CYC = CLK_HZ/1_000_000*TIMEOUT_US in BITS, ACK or RECOVER SHALL release both lines, pulse err, return to IDLE.
REQ-012 done and err SHALL never be asserted in the same cycle; ready SHALL be 0 in every state except IDLE.
REQ-013 Falling edges seen in IDLE, INHIBIT or START SHALL be ignored.
REQ-014 Counter widths SHALL be $clog2 of the larger of INHIBIT_CYC and TIMEOUT_CYC, plus one; bit index SHALL be 4 bits.

Reset
REQ-015 rst_n=0 SHALL immediately force: state IDLE, ps2_clk_oe=0, ps2_data_oe=0, ready=1, done=0, err=0, counters and bit index 0, synchronisers 1.
REQ-016 Reset mid-transfer SHALL release both lines asynchronously, with no done or err pulse.

Structure
REQ-017 Package ps2_pkg SHALL hold the FSM state typedef, and the PS/2 constants: 11 edges per frame and odd parity.
REQ-018 One sub-module ps2_sync_edge SHALL implement the synchroniser and falling-edge detector; ps2_host_tx instantiates it for ps2_clk and a plain 2-flop sync for ps2_data.

Verification (CLK_HZ=1_000_000, INHIBIT_US=100, TIMEOUT_US=2000; device model clocks at 10 kHz)
REQ-019 data=0xED, in_en one cycle -> clock low 100 cycles; bits seen at device 0,1,0,1,1,0,1,1,1,1(parity),1(stop); device acks -> done pulse, ready back to 1.
REQ-020 data=0x01 -> parity bit 0; data=0xFF -> parity bit 1; frames otherwise correct.
REQ-021 Device withholds ack (data high at edge 11) -> err pulse, no done, lines released.
REQ-022 Device stops clocking after edge 4 -> err exactly 2000 cycles after edge 4, state IDLE, both oe=0.
REQ-023 rst_n low during BITS edge 6 -> oe outputs 0 immediately, ready=1, no done/err; a following 0xF4 transfer completes normally.
REQ-024 in_en pulsed during INHIBIT with data=0x55 -> ignored; the original byte is sent unchanged.
